// File: rtl/score_display.sv
// score_display: binary score to multi-digit active-low seven-segment glyphs
// Decimal values pass through a sequential double-dabble; hex mode shows raw nibbles.
module score_display #(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex_out
);
    localparam int bw = 4 * DIGITS;
    localparam int cw = $clog2(SCORE_W + 1);
    localparam logic [31:0] dec_max = 32'(10 ** DIGITS - 1);
    localparam logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t              state, state_n;
    logic [SCORE_W-1:0]  sh;
    logic [bw-1:0]       bcd, bcd_adj, hex_src, nib;
    logic [cw-1:0]       cnt;
    logic                mode_hex, blank, ovf_lat, seen;
    logic [7*DIGITS-1:0] glyphs;
    logic [31:0]         score_ext;

    assign score_ext = 32'(score);

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    if (SCORE_W >= bw) begin : g_trunc
        assign hex_src = sh[bw-1:0];
    end else begin : g_pad
        assign hex_src = {{(bw - SCORE_W){1'b0}}, sh};
    end

    assign nib = mode_hex ? hex_src : bcd;

    // Scan from the most significant digit so "seen" marks the first nonzero one
    always_comb begin
        glyphs = '0;
        seen   = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            seen = seen | (nib[4*d +: 4] != 4'd0);
            glyphs[7*d +: 7] = ovf_lat ? 7'h3F :
                               (blank && !seen && d != 0) ? 7'h7F : glyph[nib[4*d +: 4]];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load ? (hex_mode ? UPDATE : CONVERT) : IDLE;
            CONVERT: state_n = (cnt == cw'(SCORE_W - 1)) ? UPDATE : CONVERT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            mode_hex <= 1'b0;
            blank    <= 1'b0;
            ovf_lat  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            hex_out  <= {DIGITS{7'h7F}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    sh       <= score;
                    mode_hex <= hex_mode;
                    blank    <= blank_lz;
                    bcd      <= '0;
                    cnt      <= '0;
                    busy     <= 1'b1;
                    ovf_lat  <= hex_mode ? ((score_ext >> bw) != 32'd0) : (score_ext > dec_max);
                end
                CONVERT: begin
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    cnt       <= cnt + cw'(1);
                end
                default: begin
                    hex_out <= glyphs;
                    ovf     <= ovf_lat;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: three score_display instances against an arithmetic display model
// Instances: (SCORE_W=10,DIGITS=4), (14,4), (9,2) sharing one stimulus stream.
module tb_score_display;
    logic        clk = 1'b0;
    logic        resetn, load, hex_mode, blank_lz;
    logic [13:0] score;
    logic [27:0] h0, h1;
    logic [13:0] h2;
    logic        bz [3];
    logic        dn [3];
    logic        ov [3];
    logic [27:0] hx [3];
    int          total = 0;
    int          bad = 0;

    localparam int W [3] = '{10, 14, 9};
    localparam int D [3] = '{4, 4, 2};
    localparam logic [6:0] gl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    score_display #(.SCORE_W(10), .DIGITS(4)) u0 (
        .clk(clk), .resetn(resetn), .load(load), .score(score[9:0]), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(bz[0]), .done(dn[0]), .ovf(ov[0]), .hex_out(h0));
    score_display #(.SCORE_W(14), .DIGITS(4)) u1 (
        .clk(clk), .resetn(resetn), .load(load), .score(score), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(bz[1]), .done(dn[1]), .ovf(ov[1]), .hex_out(h1));
    score_display #(.SCORE_W(9), .DIGITS(2)) u2 (
        .clk(clk), .resetn(resetn), .load(load), .score(score[8:0]), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(bz[2]), .done(dn[2]), .ovf(ov[2]), .hex_out(h2));

    assign hx[0] = h0;
    assign hx[1] = h1;
    assign hx[2] = {14'h0, h2};

    task automatic chk(input string nm, input int i, input logic [27:0] got, input logic [27:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h", nm, i, got, want);
        end
    endtask

    // Digits from plain division; a digit is blank when the value is below its weight
    function automatic logic [27:0] model_hex(input int v, input int dg, input bit hm,
                                              input bit bl, output bit o);
        logic [27:0] r = '0;
        int base = hm ? 16 : 10;
        int lim = 1;
        int p = 1;
        for (int d = 0; d < dg; d++) lim *= base;
        o = v >= lim;
        for (int d = 0; d < dg; d++) begin
            r[7*d +: 7] = o ? 7'h3F : (bl && d > 0 && v < p) ? 7'h7F : gl[(v / p) % base];
            p *= base;
        end
        return r;
    endfunction

    function automatic logic [27:0] blank_of(input int dg);
        logic [27:0] r = '0;
        for (int d = 0; d < dg; d++) r[7*d +: 7] = 7'h7F;
        return r;
    endfunction

    int          cd [3];
    logic [27:0] eh [3];
    logic [27:0] ph [3];
    bit          eo [3];
    bit          po [3];
    bit          ed [3];

    always @(posedge clk) begin
        int v;
        for (int i = 0; i < 3; i++) begin
            if (!resetn) begin
                cd[i] = 0;
                eh[i] = blank_of(D[i]);
                eo[i] = 0;
                ed[i] = 0;
            end else begin
                ed[i] = 0;
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) begin
                        eh[i] = ph[i];
                        eo[i] = po[i];
                        ed[i] = 1;
                    end
                end else if (load) begin
                    v = int'(score) & ((1 << W[i]) - 1);
                    ph[i] = model_hex(v, D[i], hex_mode, blank_lz, po[i]);
                    cd[i] = hex_mode ? 1 : W[i] + 1;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("busy", i, 28'(bz[i]), 28'(cd[i] > 0));
            chk("done", i, 28'(dn[i]), 28'(ed[i]));
            chk("ovf", i, 28'(ov[i]), 28'(eo[i]));
            chk("hex_out", i, hx[i], eh[i]);
        end
    end

    task automatic do_load(input int s, input bit hm, input bit bl);
        @(negedge clk);
        load = 1'b1;
        score = 14'(s);
        hex_mode = hm;
        blank_lz = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input int i, input int want);
        int j;
        for (j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (dn[i]) break;
        end
        chk("latency", i, 28'(j), 28'(want));
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    int bounds [14] = '{0, 9, 10, 99, 100, 511, 999, 1000, 1023, 9999, 10000, 4095, 4096, 16383};

    initial begin
        resetn = 1'b0;
        load = 1'b0;
        score = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hex", 0, h0, {4{7'h7F}});
        chk("rst_hex", 2, 28'(h2), 28'h3FFF);
        chk("rst_busy", 0, 28'(bz[0]), 28'd0);
        resetn = 1'b1;
        @(negedge clk);

        do_load(999, 0, 1);
        chk("busy_lit", 0, 28'(bz[0]), 28'd1);
        wait_done(0, 11);
        chk("dec999", 0, h0, {7'h7F, 7'h10, 7'h10, 7'h10});
        chk("dec999_ovf", 0, 28'(ov[0]), 28'd0);
        settle();

        do_load(14'h2AF, 1, 1);
        wait_done(0, 1);
        chk("hex2af_bl", 0, h0, {7'h7F, 7'h24, 7'h08, 7'h0E});
        settle();
        do_load(14'h2AF, 1, 0);
        wait_done(0, 1);
        chk("hex2af", 0, h0, {7'h40, 7'h24, 7'h08, 7'h0E});
        settle();

        do_load(0, 0, 1);
        wait_done(0, 11);
        chk("dec0", 0, h0, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        settle();
        do_load(1000, 0, 1);
        wait_done(0, 11);
        chk("dec1000", 0, h0, {7'h79, 7'h40, 7'h40, 7'h40});
        settle();

        do_load(10000, 0, 1);
        wait_done(1, 15);
        chk("dec10000", 1, h1, {4{7'h3F}});
        chk("dec10000_ovf", 1, 28'(ov[1]), 28'd1);
        settle();
        do_load(42, 0, 1);
        wait_done(1, 15);
        chk("dec42", 1, h1, {7'h7F, 7'h7F, 7'h19, 7'h24});
        chk("dec42_ovf", 1, 28'(ov[1]), 28'd0);
        settle();

        do_load(123, 0, 1);
        repeat (2) @(negedge clk);
        load = 1'b1;
        score = 14'd456;
        @(negedge clk);
        load = 1'b0;
        wait_done(0, 8);
        chk("dec123", 0, h0, {7'h7F, 7'h79, 7'h24, 7'h30});
        load = 1'b1;
        score = 14'd77;
        blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        chk("b2b_busy", 0, 28'(bz[0]), 28'd1);
        wait_done(0, 11);
        chk("dec77", 0, h0, {7'h40, 7'h40, 7'h78, 7'h78});
        settle();

        do_load(555, 0, 1);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_hex", 0, h0, {4{7'h7F}});
        chk("midrst_busy", 0, 28'(bz[0]), 28'd0);
        chk("midrst_done", 0, 28'(dn[0]), 28'd0);
        @(negedge clk);
        resetn = 1'b1;
        settle();
        do_load(321, 0, 0);
        wait_done(0, 11);
        chk("dec321", 0, h0, {7'h40, 7'h30, 7'h24, 7'h79});
        settle();

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            score = ($urandom_range(0, 1) == 0) ? 14'($urandom) : 14'(bounds[$urandom_range(0, 13)]);
            hex_mode = 1'($urandom);
            blank_lz = 1'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Parametrised multi-digit seven-segment driver for the score readout.
- Converts a binary score to per-digit glyphs on DIGITS displays:
  - decimal mode uses a sequential double-dabble binary-to-BCD converter;
  - hex mode passes nibbles directly.
- Adds leading-zero blanking, overflow indication and a load/busy/done handshake.
- Sits between the game score register and the board HEX outputs.

Parameters:
SCORE_W, 10, width of the binary score input (1..20)
DIGITS, 4, number of seven-segment digits driven (1..6)

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
load  input  1  request conversion of score; sampled only in IDLE
score  input  SCORE_W  unsigned binary score; sampled with load
hex_mode  input  1  1 = show hexadecimal, 0 = decimal; sampled with load
blank_lz  input  1  1 = blank leading zeros; sampled with load
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when hex_out has just been updated
ovf  output  1  value does not fit in DIGITS digits; held until next update
hex_out  output  7*DIGITS  digit d on bits [7d+6:7d], digit 0 = least significant

Behaviour:
- Segment coding:
  - bit 0..6 = segments a..g; active-low (0 = lit).
  - Glyphs, as 7-bit hex values {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank = 7F. Dash = 3F.
- Reset (async, resetn=0):
  - state IDLE; every hex_out digit = 7F; busy=0, done=0, ovf=0.
  - Internal shift/BCD registers cleared.
  - Reset mid-conversion aborts it; no done pulse follows.
- States: IDLE, CONVERT, UPDATE.
- IDLE:
  - On an edge with load=1: capture score, hex_mode and blank_lz; BCD register (4*DIGITS bits) = 0; bit counter = 0; busy=1.
  - Latch overflow flag:
    - decimal: score > 10^DIGITS-1;
    - hex: score >> (4*DIGITS) != 0.
  - Next state: CONVERT if decimal, else UPDATE.
- CONVERT (decimal only):
  - Each edge: add 3 to every BCD nibble >= 5, then shift {BCD, shift reg} left by 1.
  - Exactly SCORE_W iterations; after the SCORE_W-th go to UPDATE.
  - BCD bits shifted out above 4*DIGITS are discarded; the overflow flag is already latched.
- UPDATE (one cycle):
  - hex_out is registered from the nibble source: BCD register (decimal) or the low 4*DIGITS bits of the captured score (hex).
  - ovf takes the latched flag.
  - done=1 for this one cycle; busy=0; next state IDLE.
- Latency, load accepted at edge k:
  - decimal: hex_out/done valid after edge k+SCORE_W+1;
  - hex: after edge k+1.
  - busy is high from edge k until the edge that asserts done.
- Overflow: when ovf=1, every digit = 3F (dash), regardless of blank_lz.
- Leading-zero blanking (blank_lz=1, no overflow):
  - every digit above the most significant nonzero digit = 7F;
  - digit 0 is never blanked, so value 0 shows "0".
- Display and ovf hold their last value between updates.
- load asserted while busy (CONVERT or UPDATE) is ignored, not queued.
- load high in the cycle done is high is accepted (state is IDLE at that edge).
- score/mode changes while busy have no effect on the conversion in progress.
- Non-power-of-ten digits in hex mode use the full 0..F glyph set.

Test Plan:
- Reset, then SCORE_W=10, DIGITS=4, decimal, blank_lz=1, load score=999 at edge k -> busy high k..k+10; at k+11 done=1 for one cycle, hex_out = {7F,10,10,10}, ovf=0.
- Hex mode, blank_lz=1, score=0x2AF -> done at k+1, hex_out = {7F,24,08,0E}; same with blank_lz=0 -> {40,24,08,0E}.
- Decimal, score=0, blank_lz=1 -> {7F,7F,7F,40}; score=1000 -> {79,40,40,40}.
- SCORE_W=14, DIGITS=4, decimal, score=10000 -> ovf=1, all digits 3F; next load score=42 -> ovf=0, {7F,7F,19,24} (blank_lz=1).
- Load 123, then pulse load with score=456 at k+3 -> ignored; result {7F,79,24,30}, single done pulse; back-to-back load on the done cycle is accepted.
- Assert resetn=0 at k+5 during conversion -> all digits 7F immediately, busy=0, no done; after release, a new load completes normally.
